// File: rtl/pkt_pkg.sv
// ============================================================================
// pkt_pkg : state encoding, idle symbol and index sizing for the deframer
// Rev 1.0
// ============================================================================
`default_nettype none

package pkt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_TAIL = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam int IDLE_SYM = 0;

    // Body index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pkt_body_acc.sv
// ============================================================================
// pkt_body_acc : working body shift register and running XOR parity
// Rev 1.0
// ============================================================================
`default_nettype none

module pkt_body_acc
    import pkt_pkg::*;
#(
    parameter int FIELD_W  = 2,
    parameter int BODY_LEN = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        load_i,
    input  logic                        shift_i,
    input  logic [FIELD_W-1:0]          sym_i,
    output logic [FIELD_W*BODY_LEN-1:0] body_o,
    output logic [FIELD_W-1:0]          par_o
);

    logic [FIELD_W*BODY_LEN-1:0] body_q;
    logic [FIELD_W*BODY_LEN-1:0] w_shifted;
    logic [FIELD_W-1:0]          par_q;

    // Shifting in from the LSB end leaves the first body symbol in the MSBs.
    if (BODY_LEN == 1) begin : g_single
        assign w_shifted = sym_i;
    end else begin : g_multi
        assign w_shifted = {body_q[FIELD_W*(BODY_LEN-1)-1:0], sym_i};
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            body_q <= '0;
            par_q  <= '0;
        end else if (load_i) begin
            body_q <= '0;
            par_q  <= sym_i;
        end else if (shift_i) begin
            body_q <= w_shifted;
            par_q  <= par_q ^ sym_i;
        end
    end

    assign body_o = body_q;
    assign par_o  = par_q;

endmodule

`default_nettype wire

// File: rtl/pkt_deframer.sv
// ============================================================================
// pkt_deframer : head/body/tail packet deframer with tail parity check
// Rev 1.0
// ============================================================================
`default_nettype none

module pkt_deframer
    import pkt_pkg::*;
#(
    parameter int FIELD_W  = 2,
    parameter int BODY_LEN = 1,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FIELD_W-1:0]          in_sym,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_abort,
    output logic [FIELD_W-1:0]          head,
    output logic [FIELD_W*BODY_LEN-1:0] body,
    output logic [FIELD_W-1:0]          tail,
    output logic                        err,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            pkt_cnt
);

    localparam int IDX_W = idx_width(BODY_LEN);

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [FIELD_W-1:0]          head_w_q;
    logic [FIELD_W-1:0]          head_q;
    logic [FIELD_W*BODY_LEN-1:0] body_q;
    logic [FIELD_W-1:0]          tail_q;
    logic                        err_q;
    logic [CNT_W-1:0]            cnt_q;

    logic                        w_accept;
    logic                        w_acc_load;
    logic                        w_acc_shift;
    logic                        w_acc_clr;
    logic                        w_capture;
    logic                        w_cnt_inc;
    logic [FIELD_W*BODY_LEN-1:0] w_acc_body;
    logic [FIELD_W-1:0]          w_acc_par;

    assign in_ready = (state_q != ST_HOLD);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        w_acc_load  = 1'b0;
        w_acc_shift = 1'b0;
        w_acc_clr   = 1'b0;
        w_capture   = 1'b0;
        w_cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_accept && (in_sym != FIELD_W'(IDLE_SYM))) begin
                    w_acc_load = 1'b1;
                    idx_d      = '0;
                    state_d    = ST_BODY;
                end
            end
            ST_BODY: begin
                if (in_abort) begin
                    w_acc_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_accept) begin
                    w_acc_shift = 1'b1;
                    if (idx_q == IDX_W'(BODY_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = ST_TAIL;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_TAIL: begin
                if (in_abort) begin
                    w_acc_clr = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_accept) begin
                    w_capture = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_cnt_inc = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Presented fields only move on a completed tail, so aborts and idle
    // symbols never disturb what the consumer sees.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_w_q <= '0;
            head_q   <= '0;
            body_q   <= '0;
            tail_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            if (w_acc_load) begin
                head_w_q <= in_sym;
            end
            if (w_capture) begin
                head_q <= head_w_q;
                body_q <= w_acc_body;
                tail_q <= in_sym;
                err_q  <= (in_sym != w_acc_par);
            end
            if (w_cnt_inc) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    pkt_body_acc #(
        .FIELD_W  (FIELD_W),
        .BODY_LEN (BODY_LEN)
    ) u_body_acc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (w_acc_clr),
        .load_i  (w_acc_load),
        .shift_i (w_acc_shift),
        .sym_i   (in_sym),
        .body_o  (w_acc_body),
        .par_o   (w_acc_par)
    );

    assign head      = head_q;
    assign body      = body_q;
    assign tail      = tail_q;
    assign err       = err_q;
    assign out_valid = (state_q == ST_HOLD);
    assign pkt_cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_pkt_deframer.sv
// ============================================================================
// tb_pkt_deframer : scoreboard bench for two deframer configurations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pkt_deframer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: FIELD_W=2, BODY_LEN=1, CNT_W=16
    logic [1:0]  in_sym_a = '0;
    logic        in_valid_a = 1'b0, in_abort_a = 1'b0, out_ready_a = 1'b0;
    logic        in_ready_a, err_a, out_valid_a;
    logic [1:0]  head_a, body_a, tail_a;
    logic [15:0] pkt_cnt_a;

    // Instance B: FIELD_W=2, BODY_LEN=3, CNT_W=2
    logic [1:0]  in_sym_b = '0;
    logic        in_valid_b = 1'b0, in_abort_b = 1'b0, out_ready_b = 1'b0;
    logic        in_ready_b, err_b, out_valid_b;
    logic [1:0]  head_b, tail_b;
    logic [5:0]  body_b;
    logic [1:0]  pkt_cnt_b;

    pkt_deframer #(.FIELD_W(2), .BODY_LEN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_sym(in_sym_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .in_abort(in_abort_a), .head(head_a),
        .body(body_a), .tail(tail_a), .err(err_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .pkt_cnt(pkt_cnt_a)
    );

    pkt_deframer #(.FIELD_W(2), .BODY_LEN(3), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_sym(in_sym_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .in_abort(in_abort_b), .head(head_b),
        .body(body_b), .tail(tail_b), .err(err_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .pkt_cnt(pkt_cnt_b)
    );

    typedef struct {
        logic [1:0] h;
        logic [5:0] b;
        logic [1:0] t;
        logic       e;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [15:0] cnt_a = '0;
    logic [1:0]  cnt_b = '0;
    logic        post_a = 1'b0, post_b = 1'b0;
    logic        rnd_rdy = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_sym(input int sel, input logic [1:0] sym, input logic abort);
        int guard;
        @(negedge clk);
        if (sel == 0) begin
            in_sym_a = sym; in_valid_a = 1'b1; in_abort_a = abort;
        end else begin
            in_sym_b = sym; in_valid_b = 1'b1; in_abort_b = abort;
        end
        guard = 0;
        while (((sel == 0) ? in_ready_a : in_ready_b) == 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 32'(guard), 0);
        @(posedge clk);
    endtask

    task automatic end_pkt(input int sel);
        @(negedge clk);
        if (sel == 0) begin in_valid_a = 1'b0; in_abort_a = 1'b0; end
        else          begin in_valid_b = 1'b0; in_abort_b = 1'b0; end
    endtask

    // Expected parity is the XOR of head and every body symbol.
    task automatic send_pkt(input int sel, input logic [1:0] h, input logic [5:0] b,
                            input logic [1:0] t);
        exp_t       x;
        logic [1:0] p;
        int         n;
        n = (sel == 0) ? 1 : 3;
        p = h;
        for (int i = 0; i < n; i++) p = p ^ b[2*i +: 2];
        x.h = h; x.t = t; x.e = (t != p);
        x.b = (sel == 0) ? {4'b0, b[1:0]} : b;
        if (sel == 0) q_a.push_back(x); else q_b.push_back(x);
        send_sym(sel, h, 1'b0);
        for (int i = n - 1; i >= 0; i--) send_sym(sel, b[2*i +: 2], 1'b0);
        send_sym(sel, t, 1'b0);
        end_pkt(sel);
    endtask

    task automatic chk_reset_a();
        chk("rst_head", head_a, 0);
        chk("rst_body", body_a, 0);
        chk("rst_tail", tail_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_ov", out_valid_a, 0);
        chk("rst_cnt", pkt_cnt_a, 0);
        chk("rst_in_ready", in_ready_a, 1);
    endtask

    always @(negedge clk) begin
        if (rnd_rdy) out_ready_a = 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (post_a) begin
                chk("a_ov_low", out_valid_a, 0);
                chk("a_cnt", pkt_cnt_a, cnt_a);
                post_a = 1'b0;
            end
            if (out_valid_a) begin
                if (q_a.size() == 0) chk("a_unexpected_ov", out_valid_a, 0);
                else begin
                    chk("a_head", head_a, q_a[0].h);
                    chk("a_body", {4'b0, body_a}, q_a[0].b);
                    chk("a_tail", tail_a, q_a[0].t);
                    chk("a_err", err_a, q_a[0].e);
                    chk("a_in_ready_hold", in_ready_a, 0);
                    if (out_ready_a) begin
                        void'(q_a.pop_front());
                        cnt_a++;
                        post_a = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (post_b) begin
                chk("b_ov_low", out_valid_b, 0);
                chk("b_cnt", pkt_cnt_b, cnt_b);
                post_b = 1'b0;
            end
            if (out_valid_b) begin
                if (q_b.size() == 0) chk("b_unexpected_ov", out_valid_b, 0);
                else begin
                    chk("b_head", head_b, q_b[0].h);
                    chk("b_body", body_b, q_b[0].b);
                    chk("b_tail", tail_b, q_b[0].t);
                    chk("b_err", err_b, q_b[0].e);
                    if (out_ready_b) begin
                        void'(q_b.pop_front());
                        cnt_b++;
                        post_b = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_a();

        // Idle symbol dropped, then a clean packet.
        out_ready_a = 1'b1;
        send_sym(0, 2'b00, 1'b0);
        send_pkt(0, 2'b01, 6'b000001, 2'b00);
        repeat (3) @(negedge clk);

        // Parity error still delivered and counted.
        send_pkt(0, 2'b11, 6'b000011, 2'b11);
        repeat (3) @(negedge clk);

        // Back-pressure with a pending packet; abort in HOLD is ignored.
        out_ready_a = 1'b0;
        send_pkt(0, 2'b10, 6'b000011, 2'b01);
        fork
            begin
                repeat (2) @(negedge clk);
                in_abort_a = 1'b1;
                repeat (4) @(negedge clk);
                in_abort_a = 1'b0;
                out_ready_a = 1'b1;
            end
            send_pkt(0, 2'b01, 6'b000010, 2'b11);
        join
        repeat (3) @(negedge clk);

        // Abort wins over the tail symbol.
        send_sym(0, 2'b01, 1'b0);
        send_sym(0, 2'b10, 1'b0);
        send_sym(0, 2'b11, 1'b1);
        end_pkt(0);
        repeat (3) @(negedge clk);
        send_pkt(0, 2'b10, 6'b000000, 2'b10);
        repeat (3) @(negedge clk);

        // Reset in BODY.
        send_sym(0, 2'b01, 1'b0);
        @(negedge clk);
        in_valid_a = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cnt_a = '0; cnt_b = '0; post_a = 1'b0; post_b = 1'b0;
        #1;
        chk_reset_a();

        // Reset in HOLD loses the presented packet.
        out_ready_a = 1'b0;
        send_pkt(0, 2'b11, 6'b000001, 2'b10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        cnt_a = '0; post_a = 1'b0;
        #1;
        chk_reset_a();
        out_ready_a = 1'b1;
        send_pkt(0, 2'b01, 6'b000011, 2'b10);
        repeat (3) @(negedge clk);

        // Random packets with random back-pressure.
        rnd_rdy = 1'b1;
        repeat (8) send_pkt(0, 2'($urandom_range(1, 3)), 6'($urandom_range(0, 3)),
                            2'($urandom_range(0, 3)));
        guard = 0;
        while (q_a.size() != 0 && guard < 200) begin @(negedge clk); guard++; end
        rnd_rdy = 1'b0;
        out_ready_a = 1'b1;

        // BODY_LEN=3 ordering, parity and 2-bit counter wrap.
        out_ready_b = 1'b1;
        send_pkt(1, 2'b01, 6'b101100, 2'b01);
        repeat (4) send_pkt(1, 2'($urandom_range(1, 3)), 6'($urandom_range(0, 63)),
                            2'($urandom_range(0, 3)));
        guard = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_a", 32'(q_a.size()), 0);
        chk("drain_b", 32'(q_b.size()), 0);
        repeat (2) @(negedge clk);
        chk("b_wrap", pkt_cnt_b, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
